// File: rtl/time_set_controller.sv
// -----------------------------------------------------------------------------
// time_set_controller
// Timekeeping and time-set controller for a 24-hour digital clock.
// Holds hours/minutes/seconds, advances them on the 1 Hz enable in RUN, and
// sequences the set procedure RUN -> SET_HR -> SET_MIN -> RUN with inc/dec
// editing of the selected field and an inactivity timeout back to RUN.
//
// Optional feature macro: BLINK_EN
//   defined   : blink toggles on each tick_1hz while editing, cleared on edits
//               and on every mode change.
//   undefined : blink is tied to 0.
//
// Parameters:
//   TIMEOUT_S  ticks without button activity before a set mode returns to RUN
//              (1..63)
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   tick_1hz   one-clk 1 Hz enable
//   btn_mode   one-clk mode button pulse
//   btn_inc    one-clk increment pulse
//   btn_dec    one-clk decrement pulse
//   hours      current hours 0..23
//   minutes    current minutes 0..59
//   seconds    current seconds 0..59
//   mode       00 RUN, 01 SET_HR, 10 SET_MIN
//   setting    high when mode != RUN
//   blink      blank-phase indicator for the edited field
//   min_tick   one-clk pulse when seconds wrap 59->0 in RUN
// -----------------------------------------------------------------------------
module time_set_controller #(
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       setting,
  output logic       blink,
  output logic       min_tick
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  localparam logic [5:0] TLAST = 6'(TIMEOUT_S - 1);

  state_t     state_r, state_s;
  logic [4:0] hours_r, hours_s;
  logic [5:0] minutes_r, minutes_s;
  logic [5:0] seconds_r, seconds_s;
  logic [5:0] tcnt_r, tcnt_s;
  logic       blink_r, blink_s;
  logic       min_tick_r, min_tick_s;
  logic       setting_r;
  logic       any_btn_s;
  logic       timeout_s;

  assign any_btn_s = btn_mode | btn_inc | btn_dec;
  // A tick with no button activity at the last count expires the set mode.
  assign timeout_s = tick_1hz & ~any_btn_s & (tcnt_r == TLAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: btn_mode steps the cycle, timeout returns to RUN.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RUN: begin
        if (btn_mode) state_s = SET_HR;
        else          state_s = RUN;
      end
      SET_HR: begin
        if (btn_mode)       state_s = SET_MIN;
        else if (timeout_s) state_s = RUN;
        else                state_s = SET_HR;
      end
      SET_MIN: begin
        if (btn_mode)       state_s = RUN;
        else if (timeout_s) state_s = RUN;
        else                state_s = SET_MIN;
      end
      default: state_s = RUN;
    endcase
  end

  // Output/datapath next values: counting in RUN, editing and timeout in set modes.
  always_comb begin
    hours_s    = hours_r;
    minutes_s  = minutes_r;
    seconds_s  = seconds_r;
    tcnt_s     = tcnt_r;
    min_tick_s = 1'b0;
    case (state_r)
      RUN: begin
        tcnt_s = 6'd0;
        if (btn_mode) begin
          // Mode change takes priority over a coincident tick.
          seconds_s = seconds_r;
        end else if (tick_1hz) begin
          if (seconds_r == 6'd59) begin
            seconds_s  = 6'd0;
            min_tick_s = 1'b1;
            if (minutes_r == 6'd59) begin
              minutes_s = 6'd0;
              hours_s   = (hours_r == 5'd23) ? 5'd0 : hours_r + 5'd1;
            end else begin
              minutes_s = minutes_r + 6'd1;
            end
          end else begin
            seconds_s = seconds_r + 6'd1;
          end
        end else begin
          seconds_s = seconds_r;
        end
      end
      SET_HR, SET_MIN: begin
        if (btn_mode) begin
          tcnt_s = 6'd0;
          if (state_s == RUN) seconds_s = 6'd0;
          else                seconds_s = seconds_r;
        end else if (btn_inc | btn_dec) begin
          tcnt_s = 6'd0;
          // Simultaneous inc and dec cancel; only the counter is cleared.
          if (btn_inc && !btn_dec) begin
            if (state_r == SET_HR) hours_s   = (hours_r == 5'd23)   ? 5'd0 : hours_r + 5'd1;
            else                   minutes_s = (minutes_r == 6'd59) ? 6'd0 : minutes_r + 6'd1;
          end else if (btn_dec && !btn_inc) begin
            if (state_r == SET_HR) hours_s   = (hours_r == 5'd0)   ? 5'd23 : hours_r - 5'd1;
            else                   minutes_s = (minutes_r == 6'd0) ? 6'd59 : minutes_r - 6'd1;
          end else begin
            hours_s = hours_r;
          end
        end else if (tick_1hz) begin
          if (timeout_s) begin
            tcnt_s    = 6'd0;
            seconds_s = 6'd0;
          end else begin
            tcnt_s = tcnt_r + 6'd1;
          end
        end else begin
          tcnt_s = tcnt_r;
        end
      end
      default: begin
        tcnt_s    = 6'd0;
        seconds_s = 6'd0;
      end
    endcase
  end

`ifdef BLINK_EN
  // Blink phase: cleared on mode change, RUN, or any edit; toggles per tick while editing.
  always_comb begin
    blink_s = 1'b0;
    if (state_r == RUN || state_s != state_r || any_btn_s) begin
      blink_s = 1'b0;
    end else if (tick_1hz) begin
      blink_s = ~blink_r;
    end else begin
      blink_s = blink_r;
    end
  end
`else
  // Blink feature disabled: indicator held low.
  always_comb begin
    blink_s = 1'b0;
  end
`endif

  // Registered outputs and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hours_r    <= 5'd0;
      minutes_r  <= 6'd0;
      seconds_r  <= 6'd0;
      tcnt_r     <= 6'd0;
      blink_r    <= 1'b0;
      min_tick_r <= 1'b0;
      setting_r  <= 1'b0;
    end else begin
      hours_r    <= hours_s;
      minutes_r  <= minutes_s;
      seconds_r  <= seconds_s;
      tcnt_r     <= tcnt_s;
      blink_r    <= blink_s;
      min_tick_r <= min_tick_s;
      setting_r  <= (state_s != RUN);
    end
  end

  assign hours    = hours_r;
  assign minutes  = minutes_r;
  assign seconds  = seconds_r;
  assign mode     = state_r;
  assign setting  = setting_r;
  assign blink    = blink_r;
  assign min_tick = min_tick_r;

endmodule
